// File: rtl/datamover_tcdm_lane_aligner.sv
// Splits one wide HCI request into MP 32-bit TCDM lanes with per-lane grant tracking and
// re-aligns skewed lane responses. Optional stall counter: DATAMOVER_LANE_ALIGNER_STATS_EN.
module datamover_tcdm_lane_aligner #(
  parameter int unsigned DW        = 288,
  parameter int unsigned MP        = DW / 32,
  parameter int unsigned IW        = 8,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             w_req_i,
  output logic             w_gnt_o,
  input  logic [31:0]      w_add_i,
  input  logic             w_wen_i,
  input  logic [MP*4-1:0]  w_be_i,
  input  logic [DW-1:0]    w_data_i,
  input  logic [IW-1:0]    w_id_i,
  input  logic             w_r_ready_i,
  output logic             w_r_valid_o,
  output logic [DW-1:0]    w_r_data_o,
  output logic [IW-1:0]    w_r_id_o,
  output logic [MP-1:0]    tcdm_req_o,
  input  logic [MP-1:0]    tcdm_gnt_i,
  output logic [MP*32-1:0] tcdm_add_o,
  output logic [MP-1:0]    tcdm_wen_o,
  output logic [MP*4-1:0]  tcdm_be_o,
  output logic [MP*32-1:0] tcdm_data_o,
  input  logic [MP-1:0]    tcdm_r_valid_i,
  input  logic [MP*32-1:0] tcdm_r_data_i,
  output logic [31:0]      stall_cnt_o
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam logic [CntW-1:0] DepthC  = CntW'(RSP_DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(RSP_DEPTH - 1);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  logic [MP-1:0]    granted_q, granted_d, lane_gnt;
  logic             can_issue, pop;
  logic [CntW-1:0]  outst_q, outst_d;
  logic [PtrW-1:0]  id_wr_q, id_rd_q;
  logic [IW-1:0]    id_mem_q [RSP_DEPTH];
  logic [MP*32-1:0] lane_head;
  logic [MP-1:0]    lane_ne;

  // Request side: a lane drops its req once granted and waits for the remaining lanes.
  always_comb begin
    can_issue  = w_req_i && (outst_q < DepthC);
    tcdm_req_o = {MP{can_issue}} & ~granted_q;
    lane_gnt   = tcdm_req_o & tcdm_gnt_i;
    w_gnt_o    = can_issue && (&(granted_q | lane_gnt));
    granted_d  = w_gnt_o ? '0 : (granted_q | lane_gnt);
  end

  for (genvar i = 0; i < MP; i++) begin : g_lane_add
    assign tcdm_add_o[32*i+:32] = w_add_i + 32'(4 * i);
  end
  assign tcdm_wen_o  = {MP{w_wen_i}};
  assign tcdm_be_o   = w_be_i;
  assign tcdm_data_o = w_data_i;

  assign w_r_valid_o = &lane_ne;
  assign pop         = w_r_valid_o && w_r_ready_i;
  assign w_r_data_o  = w_r_valid_o ? lane_head : '0;
  assign w_r_id_o    = w_r_valid_o ? id_mem_q[id_rd_q] : '0;

  always_comb begin
    outst_d = outst_q;
    if (w_gnt_o && !pop) begin
      outst_d = outst_q + 1'b1;
    end else if (!w_gnt_o && pop) begin
      outst_d = outst_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      granted_q <= '0;
      outst_q   <= '0;
      id_wr_q   <= '0;
      id_rd_q   <= '0;
    end else if (clear_i) begin
      granted_q <= '0;
      outst_q   <= '0;
      id_wr_q   <= '0;
      id_rd_q   <= '0;
    end else begin
      granted_q <= granted_d;
      outst_q   <= outst_d;
      if (w_gnt_o) id_wr_q <= ptr_inc(id_wr_q);
      if (pop)     id_rd_q <= ptr_inc(id_rd_q);
    end
  end

  // Storage needs no reset: the heads are masked while the FIFOs are empty.
  always_ff @(posedge clk_i) begin
    if (w_gnt_o) id_mem_q[id_wr_q] <= w_id_i;
  end

  for (genvar i = 0; i < MP; i++) begin : g_lane_fifo
    logic [31:0]     mem_q [RSP_DEPTH];
    logic [PtrW-1:0] wr_q, rd_q;
    logic [CntW-1:0] cnt_q;
    logic            push;

    assign push = tcdm_r_valid_i[i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else if (clear_i) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) wr_q <= ptr_inc(wr_q);
        if (pop)  rd_q <= ptr_inc(rd_q);
        if (push && !pop) begin
          cnt_q <= cnt_q + 1'b1;
        end else if (!push && pop) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_q] <= tcdm_r_data_i[32*i+:32];
    end

    assign lane_head[32*i+:32] = mem_q[rd_q];
    assign lane_ne[i]          = (cnt_q != '0);

`ifndef SYNTHESIS
    a_lane_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push && !clear_i && (cnt_q == DepthC) && !pop))
      else $error("lane %0d response with full FIFO", i);
`endif
  end

`ifndef SYNTHESIS
  a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_req_i && !w_gnt_o && !clear_i) |=> w_req_i)
    else $error("w_req_i dropped before w_gnt_o");
`endif

`ifdef DATAMOVER_LANE_ALIGNER_STATS_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (clear_i) begin
      stall_q <= '0;
    end else if (w_req_i && !w_gnt_o && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_datamover_tcdm_lane_aligner.sv
// Self-checking bench for datamover_tcdm_lane_aligner: vector table, directed corner sequences
// and a randomized run against a transaction-level model.
module tb_datamover_tcdm_lane_aligner;
  localparam int DW = 288;
  localparam int MP = 9;
  localparam int IW = 8;
  typedef logic [DW-1:0] w_t;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             clear_i;
  logic             w_req_i;
  logic             w_gnt_o;
  logic [31:0]      w_add_i;
  logic             w_wen_i;
  logic [MP*4-1:0]  w_be_i;
  logic [DW-1:0]    w_data_i;
  logic [IW-1:0]    w_id_i;
  logic             w_r_ready_i;
  logic             w_r_valid_o;
  logic [DW-1:0]    w_r_data_o;
  logic [IW-1:0]    w_r_id_o;
  logic [MP-1:0]    tcdm_req_o;
  logic [MP-1:0]    tcdm_gnt_i;
  logic [MP*32-1:0] tcdm_add_o;
  logic [MP-1:0]    tcdm_wen_o;
  logic [MP*4-1:0]  tcdm_be_o;
  logic [MP*32-1:0] tcdm_data_o;
  logic [MP-1:0]    tcdm_r_valid_i;
  logic [MP*32-1:0] tcdm_r_data_i;
  logic [31:0]      stall_cnt_o;

  datamover_tcdm_lane_aligner #(
    .DW(DW), .MP(MP), .IW(IW), .RSP_DEPTH(2)
  ) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .w_req_i(w_req_i), .w_gnt_o(w_gnt_o), .w_add_i(w_add_i), .w_wen_i(w_wen_i),
    .w_be_i(w_be_i), .w_data_i(w_data_i), .w_id_i(w_id_i), .w_r_ready_i(w_r_ready_i),
    .w_r_valid_o(w_r_valid_o), .w_r_data_o(w_r_data_o), .w_r_id_o(w_r_id_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input w_t act, input w_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  function automatic w_t lanes(input logic [31:0] base);
    w_t r = '0;
    for (int i = 0; i < MP; i++) r[32*i+:32] = base + 32'(i);
    return r;
  endfunction

  task automatic set_rsp(input logic [MP-1:0] mask, input logic [31:0] base);
    tcdm_r_valid_i = mask;
    tcdm_r_data_i  = lanes(base);
  endtask

  task automatic idle();
    clear_i = 0; w_req_i = 0; w_add_i = '0; w_wen_i = 0; w_be_i = '0; w_data_i = '0;
    w_id_i = '0; w_r_ready_i = 1; tcdm_gnt_i = '0; tcdm_r_valid_i = '0; tcdm_r_data_i = '0;
  endtask

  task automatic clear_pulse();
    cyc(); clear_i = 1; tcdm_gnt_i = '0; tcdm_r_valid_i = '0;
    cyc(); clear_i = 0; w_req_i = 0;
  endtask

  typedef struct {
    logic          req;
    logic          wen;
    logic [31:0]   add;
    logic [MP-1:0] gnt;
    logic [MP-1:0] exp_req;
    logic          exp_gnt;
    logic [31:0]   exp_a0;
    logic [31:0]   exp_a8;
  } vec_t;
  vec_t tbl [6];

  // Randomized-run model state
  int            lane_acc [MP];
  int            wide_gnts, pops, outst;
  int            pend_due [MP][$];
  logic [31:0]   pend_dat [MP][$];
  logic [31:0]   lq [MP][$];
  logic [IW-1:0] idq [$];
  logic [MP-1:0] e_req, dlv;
  logic          e_all, e_gnt, e_val, can, active, drained;
  w_t            e_dat;
  logic [31:0]   r_add;
  logic [IW-1:0] r_id;
  logic          r_wen;
  int            lane_gnt_tot, k;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b1, 32'h0000_1000, 9'h1ff, 9'h000, 1'b0, 32'h0000_1000, 32'h0000_1020};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_1000, 9'h1ff, 9'h1ff, 1'b1, 32'h0000_1000, 32'h0000_1020};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_2000, 9'h0f0, 9'h1ff, 1'b0, 32'h0000_2000, 32'h0000_2020};
    tbl[3] = '{1'b1, 1'b1, 32'hffff_fff0, 9'h000, 9'h1ff, 1'b0, 32'hffff_fff0, 32'h0000_0010};
    tbl[4] = '{1'b1, 1'b0, 32'hffff_fffc, 9'h1fe, 9'h1ff, 1'b0, 32'hffff_fffc, 32'h0000_001c};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0000, 9'h1ff, 9'h1ff, 1'b1, 32'h0000_0000, 32'h0000_0020};

    idle();
    rst_ni = 0;
    #12;
    chk("rst_w_gnt", w_t'(w_gnt_o), '0);
    chk("rst_r_valid", w_t'(w_r_valid_o), '0);
    chk("rst_r_data", w_r_data_o, '0);
    chk("rst_r_id", w_t'(w_r_id_o), '0);
    chk("rst_tcdm_req", w_t'(tcdm_req_o), '0);
    chk("rst_stall", w_t'(stall_cnt_o), '0);
    @(negedge clk_i);
    rst_ni = 1;

    // Single-cycle vectors, each from a freshly cleared state
    for (int v = 0; v < 6; v++) begin
      cyc();
      w_req_i = tbl[v].req; w_wen_i = tbl[v].wen; w_add_i = tbl[v].add;
      tcdm_gnt_i = tbl[v].gnt; w_id_i = IW'(v);
      w_be_i = {4'($urandom), $urandom};
      for (int i = 0; i < MP; i++) w_data_i[32*i+:32] = $urandom;
      settle();
      chk($sformatf("vec%0d_req", v), w_t'(tcdm_req_o), w_t'(tbl[v].exp_req));
      chk($sformatf("vec%0d_gnt", v), w_t'(w_gnt_o), w_t'(tbl[v].exp_gnt));
      chk($sformatf("vec%0d_add0", v), w_t'(tcdm_add_o[31:0]), w_t'(tbl[v].exp_a0));
      chk($sformatf("vec%0d_add8", v), w_t'(tcdm_add_o[287:256]), w_t'(tbl[v].exp_a8));
      chk($sformatf("vec%0d_wen", v), w_t'(tcdm_wen_o), w_t'({MP{tbl[v].wen}}));
      chk($sformatf("vec%0d_be3", v), w_t'(tcdm_be_o[15:12]), w_t'(w_be_i[15:12]));
      chk($sformatf("vec%0d_dat5", v), w_t'(tcdm_data_o[191:160]), w_t'(w_data_i[191:160]));
      clear_pulse();
    end

    // T1: all lanes granted at once, lane data = lane index
    cyc(); w_req_i = 1; w_wen_i = 1; w_add_i = 32'h1000; w_id_i = 8'h03; tcdm_gnt_i = '1;
    settle();
    chk("t1_gnt", w_t'(w_gnt_o), w_t'(1));
    chk("t1_add8", w_t'(tcdm_add_o[287:256]), w_t'(32'h1020));
    cyc(); w_req_i = 0; tcdm_gnt_i = '0; set_rsp('1, 32'h0);
    settle();
    chk("t1_no_bypass", w_t'(w_r_valid_o), '0);
    cyc(); set_rsp('0, 32'h0);
    settle();
    chk("t1_valid", w_t'(w_r_valid_o), w_t'(1));
    chk("t1_data", w_r_data_o, lanes(32'h0));
    chk("t1_id", w_t'(w_r_id_o), w_t'(8'h03));
    cyc();
    settle();
    chk("t1_popped", w_t'(w_r_valid_o), '0);

    // T2: lane 0 granted first, the rest three cycles later; T3 follows with skewed responses
    clear_pulse();
    lane_gnt_tot = 0;
    cyc(); w_req_i = 1; w_add_i = 32'h3000; w_id_i = 8'h22; tcdm_gnt_i = 9'h001;
    settle();
    chk("t2_c0_req", w_t'(tcdm_req_o), w_t'(9'h1ff));
    chk("t2_c0_gnt", w_t'(w_gnt_o), '0);
    lane_gnt_tot += $countones(tcdm_req_o & tcdm_gnt_i);
    for (int c = 1; c < 3; c++) begin
      cyc();
      settle();
      chk($sformatf("t2_c%0d_req", c), w_t'(tcdm_req_o), w_t'(9'h1fe));
      chk($sformatf("t2_c%0d_gnt", c), w_t'(w_gnt_o), '0);
      lane_gnt_tot += $countones(tcdm_req_o & tcdm_gnt_i);
    end
    cyc(); tcdm_gnt_i = '1;
    settle();
    chk("t2_c3_req", w_t'(tcdm_req_o), w_t'(9'h1fe));
    chk("t2_c3_gnt", w_t'(w_gnt_o), w_t'(1));
    lane_gnt_tot += $countones(tcdm_req_o & tcdm_gnt_i);
    cyc(); w_req_i = 0; tcdm_gnt_i = '0; set_rsp(9'h0ff, 32'ha0);
    settle();
    chk("t2_lane_gnts", w_t'(lane_gnt_tot), w_t'(9));
`ifdef DATAMOVER_LANE_ALIGNER_STATS_EN
    chk("t2_stall", w_t'(stall_cnt_o), w_t'(3));
`else
    chk("t2_stall", w_t'(stall_cnt_o), w_t'(0));
`endif
    cyc(); set_rsp('0, 32'h0);
    settle();
    chk("t3_wait1", w_t'(w_r_valid_o), '0);
    cyc();
    settle();
    chk("t3_wait2", w_t'(w_r_valid_o), '0);
    cyc(); set_rsp(9'h100, 32'ha0);
    settle();
    chk("t3_wait3", w_t'(w_r_valid_o), '0);
    cyc(); set_rsp('0, 32'h0);
    settle();
    chk("t3_valid", w_t'(w_r_valid_o), w_t'(1));
    chk("t3_data", w_r_data_o, lanes(32'ha0));
    chk("t3_id", w_t'(w_r_id_o), w_t'(8'h22));
    cyc();
    settle();
    chk("t3_single_beat", w_t'(w_r_valid_o), '0);

    // T4: third read blocked until one response retires
    cyc(); w_req_i = 1; w_id_i = 8'h41; w_add_i = 32'h4000; tcdm_gnt_i = '1;
    settle();
    chk("t4_a_gnt", w_t'(w_gnt_o), w_t'(1));
    cyc(); w_id_i = 8'h42; w_add_i = 32'h4100;
    settle();
    chk("t4_b_gnt", w_t'(w_gnt_o), w_t'(1));
    cyc(); w_id_i = 8'h43; w_add_i = 32'h4200;
    settle();
    chk("t4_c_req", w_t'(tcdm_req_o), '0);
    chk("t4_c_gnt", w_t'(w_gnt_o), '0);
    cyc(); set_rsp('1, 32'h4100_0000);
    settle();
    chk("t4_c_req2", w_t'(tcdm_req_o), '0);
    cyc(); set_rsp('0, 32'h0);
    settle();
    chk("t4_a_valid", w_t'(w_r_valid_o), w_t'(1));
    chk("t4_a_id", w_t'(w_r_id_o), w_t'(8'h41));
    chk("t4_a_data", w_r_data_o, lanes(32'h4100_0000));
    chk("t4_c_req3", w_t'(tcdm_req_o), '0);
    cyc(); set_rsp('1, 32'h4200_0000);
    settle();
    chk("t4_c_req4", w_t'(tcdm_req_o), w_t'(9'h1ff));
    chk("t4_c_gnt2", w_t'(w_gnt_o), w_t'(1));
    cyc(); w_req_i = 0; tcdm_gnt_i = '0; set_rsp('1, 32'h4300_0000);
    settle();
    chk("t4_b_id", w_t'(w_r_id_o), w_t'(8'h42));
    chk("t4_b_data", w_r_data_o, lanes(32'h4200_0000));
    cyc(); set_rsp('0, 32'h0);
    settle();
    chk("t4_c_id", w_t'(w_r_id_o), w_t'(8'h43));
    chk("t4_c_data", w_r_data_o, lanes(32'h4300_0000));
    cyc();
    settle();
    chk("t4_empty", w_t'(w_r_valid_o), '0);

    // T5: two buffered responses held under backpressure, then released in order
    cyc(); w_req_i = 1; w_id_i = 8'h51; w_add_i = 32'h5000; tcdm_gnt_i = '1; w_r_ready_i = 0;
    settle();
    chk("t5_a_gnt", w_t'(w_gnt_o), w_t'(1));
    cyc(); w_id_i = 8'h52; set_rsp('1, 32'h5100_0000);
    settle();
    chk("t5_b_gnt", w_t'(w_gnt_o), w_t'(1));
    cyc(); w_req_i = 0; tcdm_gnt_i = '0; set_rsp('1, 32'h5200_0000);
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("t5_hold%0d_valid", c), w_t'(w_r_valid_o), w_t'(1));
      chk($sformatf("t5_hold%0d_id", c), w_t'(w_r_id_o), w_t'(8'h51));
      chk($sformatf("t5_hold%0d_data", c), w_r_data_o, lanes(32'h5100_0000));
      cyc(); set_rsp('0, 32'h0);
      if (c == 1) w_r_ready_i = 1;
    end
    settle();
    chk("t5_b_valid", w_t'(w_r_valid_o), w_t'(1));
    chk("t5_b_id", w_t'(w_r_id_o), w_t'(8'h52));
    chk("t5_b_data", w_r_data_o, lanes(32'h5200_0000));
    cyc();
    settle();
    chk("t5_empty", w_t'(w_r_valid_o), '0);

    // T6: clear with a partial grant and one stray lane response buffered
    cyc(); w_req_i = 1; w_id_i = 8'h61; w_add_i = 32'h6000; tcdm_gnt_i = 9'h007;
    settle();
    chk("t6_c0_gnt", w_t'(w_gnt_o), '0);
    cyc(); tcdm_gnt_i = '0; set_rsp(9'h001, 32'hdead_0000);
    settle();
    chk("t6_c1_req", w_t'(tcdm_req_o), w_t'(9'h1f8));
    cyc(); clear_i = 1; set_rsp('0, 32'h0);
    cyc(); clear_i = 0;
    settle();
    chk("t6_req_all", w_t'(tcdm_req_o), w_t'(9'h1ff));
    chk("t6_valid", w_t'(w_r_valid_o), '0);
    cyc(); tcdm_gnt_i = '1;
    settle();
    chk("t6_gnt", w_t'(w_gnt_o), w_t'(1));
    cyc(); w_req_i = 0; tcdm_gnt_i = '0; set_rsp('1, 32'h6100_0000);
    cyc(); set_rsp('0, 32'h0);
    settle();
    chk("t6_rsp_data", w_r_data_o, lanes(32'h6100_0000));
    chk("t6_rsp_id", w_t'(w_r_id_o), w_t'(8'h61));
    cyc();
    settle();
    chk("t6_empty", w_t'(w_r_valid_o), '0);

    // Randomized run against the transaction-level model
    clear_pulse();
    for (int i = 0; i < MP; i++) lane_acc[i] = 0;
    wide_gnts = 0; pops = 0; active = 0; drained = 0;
    r_add = '0; r_id = '0; r_wen = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (!active && n < 2500 && $urandom_range(0, 2) != 0) begin
        active = 1;
        r_add = $urandom & 32'hffff_fffc;
        r_id = IW'($urandom);
        r_wen = 1'($urandom_range(0, 1));
        w_be_i = {4'($urandom), $urandom};
        for (int i = 0; i < MP; i++) w_data_i[32*i+:32] = $urandom;
      end
      w_req_i = active; w_add_i = r_add; w_id_i = r_id; w_wen_i = r_wen;
      for (int i = 0; i < MP; i++) tcdm_gnt_i[i] = ($urandom_range(0, 3) != 0);
      dlv = '0;
      tcdm_r_data_i = '0;
      for (int i = 0; i < MP; i++) begin
        if (pend_due[i].size() > 0 && pend_due[i][0] <= n) begin
          dlv[i] = 1;
          tcdm_r_data_i[32*i+:32] = pend_dat[i][0];
        end
      end
      tcdm_r_valid_i = dlv;
      w_r_ready_i = (n >= 2500) || ($urandom_range(0, 3) != 0);
      settle();

      outst = wide_gnts - pops;
      can = active && (outst < 2);
      e_all = 1;
      for (int i = 0; i < MP; i++) begin
        e_req[i] = can && (lane_acc[i] == wide_gnts);
        if (!((lane_acc[i] > wide_gnts) || (e_req[i] && tcdm_gnt_i[i]))) e_all = 0;
      end
      e_gnt = can && e_all;
      e_val = 1;
      e_dat = '0;
      for (int i = 0; i < MP; i++) begin
        if (lq[i].size() == 0) e_val = 0;
        else e_dat[32*i+:32] = lq[i][0];
      end
      k = $urandom_range(0, MP - 1);
      chk("rnd_req", w_t'(tcdm_req_o), w_t'(e_req));
      chk("rnd_gnt", w_t'(w_gnt_o), w_t'(e_gnt));
      chk("rnd_valid", w_t'(w_r_valid_o), w_t'(e_val));
      chk("rnd_add", w_t'(tcdm_add_o[32*k+:32]), w_t'(r_add + 32'(4 * k)));
      if (e_val) begin
        chk("rnd_data", w_r_data_o, e_dat);
        chk("rnd_id", w_t'(w_r_id_o), w_t'((idq.size() > 0) ? idq[0] : 8'h0));
      end

      for (int i = 0; i < MP; i++) begin
        if (e_req[i] && tcdm_gnt_i[i]) begin
          lane_acc[i]++;
          pend_due[i].push_back(n + $urandom_range(1, 3));
          pend_dat[i].push_back($urandom);
        end
      end
      if (e_gnt) begin
        wide_gnts++;
        idq.push_back(r_id);
        active = 0;
      end
      if (e_val && w_r_ready_i) begin
        pops++;
        if (idq.size() > 0) void'(idq.pop_front());
        for (int i = 0; i < MP; i++) void'(lq[i].pop_front());
      end
      for (int i = 0; i < MP; i++) begin
        if (dlv[i]) begin
          lq[i].push_back(pend_dat[i].pop_front());
          void'(pend_due[i].pop_front());
        end
      end

      if (n >= 2500 && !active && wide_gnts == pops) begin
        drained = 1;
        for (int i = 0; i < MP; i++) if (pend_due[i].size() != 0 || lq[i].size() != 0) drained = 0;
        if (drained) break;
      end
    end
    if (!drained) begin
      n_tests++;
      n_fail++;
      $display("FAIL rnd_drain: traffic still pending at cycle budget, required fully drained");
    end
    cyc(); idle();
    settle();
    chk("rnd_final_valid", w_t'(w_r_valid_o), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
